mem_arbiter: RTL

Shares the single main-memory port between two requesters. Requester 0 is the CPU datapath, driven by the controller's mem_read/mem_write strobes via a request wrapper. Requester 1 is the host loader/checker, which writes programs during IN and reads back during CHECK. The block arbitrates between them, sequences each access over a fixed memory latency, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and main memory.
// The master view belongs to the requesters and the memory model.
// The slave view belongs to the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [1:0]        cpustate;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              owner;

   modport master (
      output cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output host_req, host_we, host_addr, host_wdata, mem_rdata,
      input  cpu_ack, cpu_rdata, host_ack, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport slave (
      input  cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_addr, host_wdata, mem_rdata,
      output cpu_ack, cpu_rdata, host_ack, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single main-memory port.
// The CPU is only granted while cpustate equals RUN_STATE. Ties are broken
// round robin. Each access holds the memory for MEM_LAT cycles and then
// gives the grantee a one-cycle acknowledge.
module mem_arbiter #(
   parameter int         ADDR_W    = 16,
   parameter int         DATA_W    = 8,
   parameter int         MEM_LAT   = 1,
   parameter logic [1:0] RUN_STATE = 2'b11
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t            state;
   logic [3:0]        count;
   logic              last_owner;
   logic              cpu_eligible;
   logic              grant_cpu;
   logic              grant_host;
   logic              cpu_ack_r;
   logic              host_ack_r;
   logic [DATA_W-1:0] cpu_rdata_r;
   logic [DATA_W-1:0] host_rdata_r;
   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              busy_r;
   logic              owner_r;

   // Grant decision: a lone eligible requester wins, and a tie goes to the
   // requester that was not served last.
   always_comb begin
      cpu_eligible = bus.cpu_req && (bus.cpustate == RUN_STATE);
      grant_cpu    = cpu_eligible && (!bus.host_req || last_owner);
      grant_host   = bus.host_req && (!cpu_eligible || !last_owner);
   end

   // Transaction sequencer. The grantee's fields are latched straight into
   // the memory-side registers, so later request changes cannot disturb
   // the access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= 4'd0;
         last_owner   <= 1'b1;
         cpu_ack_r    <= 1'b0;
         host_ack_r   <= 1'b0;
         cpu_rdata_r  <= '0;
         host_rdata_r <= '0;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
         busy_r       <= 1'b0;
         owner_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_cpu || grant_host) begin
                  owner_r     <= grant_host;
                  last_owner  <= grant_host;
                  mem_we_r    <= grant_host ? bus.host_we    : bus.cpu_we;
                  mem_addr_r  <= grant_host ? bus.host_addr  : bus.cpu_addr;
                  mem_wdata_r <= grant_host ? bus.host_wdata : bus.cpu_wdata;
                  mem_en_r    <= 1'b1;
                  busy_r      <= 1'b1;
                  count       <= LAT_LAST;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (count == 4'd0) begin
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  if (!mem_we_r) begin
                     if (owner_r) begin
                        host_rdata_r <= bus.mem_rdata;
                     end else begin
                        cpu_rdata_r <= bus.mem_rdata;
                     end
                  end
                  if (owner_r) begin
                     host_ack_r <= 1'b1;
                  end else begin
                     cpu_ack_r <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: begin
               cpu_ack_r  <= 1'b0;
               host_ack_r <= 1'b0;
               busy_r     <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // All outputs come directly from registers, so they are glitch-free.
   always_comb begin
      bus.cpu_ack    = cpu_ack_r;
      bus.host_ack   = host_ack_r;
      bus.cpu_rdata  = cpu_rdata_r;
      bus.host_rdata = host_rdata_r;
      bus.mem_en     = mem_en_r;
      bus.mem_we     = mem_we_r;
      bus.mem_addr   = mem_addr_r;
      bus.mem_wdata  = mem_wdata_r;
      bus.busy       = busy_r;
      bus.owner      = owner_r;
   end
endmodule
